// File: rtl/clk_div_pkg.sv
// Shared types and constants for the reference-clock divider.
package clk_div_pkg;

  localparam int unsigned DIV_W_DEF  = 8;
  // Ratios below this value pass the reference clock straight through.
  localparam int unsigned BYPASS_MAX = 2;

  typedef enum logic [1:0] {
    ST_STOP,
    ST_BYPASS,
    ST_LOW,
    ST_HIGH
  } state_e;

  typedef enum logic [1:0] {
    SEL_OFF,
    SEL_REF,
    SEL_DIV
  } sel_e;

  function automatic sel_e sel_of(state_e s);
    case (s)
      ST_BYPASS:       return SEL_REF;
      ST_LOW, ST_HIGH: return SEL_DIV;
      default:         return SEL_OFF;
    endcase
  endfunction

endpackage

// File: rtl/clk_div_odd_ext.sv
// Falling-edge copy of the divided-high flag; ORed in by the top to
// stretch odd-ratio high phases by half a reference cycle.
module clk_div_odd_ext (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic hi_i,
  input  logic odd_i,
  output logic ext_o
);

  logic ext_q;

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ext_q <= 1'b0;
    else         ext_q <= hi_i & odd_i;
  end

  assign ext_o = ext_q;

endmodule

// File: rtl/clk_div_gen.sv
// Programmable reference-clock divider with bypass and glitch-free ratio reload.
// Define CLK_DIV_ODD50_EN to get exact 50% duty on odd ratios.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic             i_clk_en,
  input  logic [DIV_W-1:0] i_div_ratio,
  input  logic             i_load,
  output logic             o_div_clk,
  output logic             o_tick,
  output logic             o_ratio_ack
);

  localparam logic [DIV_W-1:0] THR = DIV_W'(BYPASS_MAX);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  state_e           state_q;
  sel_e             sel_q;
  logic [DIV_W-1:0] cnt_q, r_act_q, r_shd_q;
  logic             pend_q, div_q, tick_q, ack_q;

  logic [DIV_W-1:0] half, lo_last, hi_last, load_ratio_d;
  logic             div_out;

  assign half         = {1'b0, r_act_q[DIV_W-1:1]};
  assign lo_last      = half + DIV_W'(r_act_q[0]) - ONE;
  assign hi_last      = half - ONE;
  // A load landing exactly on the boundary wins over the shadow copy.
  assign load_ratio_d = i_load ? i_div_ratio : r_shd_q;

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_STOP;
      sel_q   <= SEL_OFF;
      cnt_q   <= '0;
      r_act_q <= '0;
      r_shd_q <= '0;
      pend_q  <= 1'b0;
      div_q   <= 1'b0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      ack_q  <= 1'b0;
      if (!div_q) sel_q <= sel_of(state_q);
      if (i_load) begin
        r_shd_q <= i_div_ratio;
        pend_q  <= 1'b1;
      end
      case (state_q)
        ST_STOP: begin
          div_q <= 1'b0;
          if (i_clk_en) begin
            r_act_q <= i_div_ratio;
            ack_q   <= 1'b1;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            if (i_div_ratio < THR) begin
              state_q <= ST_BYPASS;
              sel_q   <= SEL_REF;
              tick_q  <= 1'b1;
            end else begin
              state_q <= ST_LOW;
              sel_q   <= SEL_DIV;
            end
          end
        end
        ST_BYPASS: begin
          div_q <= 1'b0;
          if (!i_clk_en) begin
            state_q <= ST_STOP;
            sel_q   <= SEL_OFF;
          end else if (pend_q) begin
            r_act_q <= r_shd_q;
            ack_q   <= 1'b1;
            pend_q  <= i_load;
            cnt_q   <= '0;
            if (r_shd_q < THR) begin
              tick_q <= 1'b1;
            end else begin
              state_q <= ST_LOW;
              sel_q   <= SEL_DIV;
            end
          end else begin
            tick_q <= 1'b1;
          end
        end
        ST_LOW: begin
          if (cnt_q == lo_last) begin
            cnt_q   <= '0;
            state_q <= ST_HIGH;
            div_q   <= 1'b1;
            tick_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE;
            div_q <= 1'b0;
          end
        end
        ST_HIGH: begin
          if (cnt_q == hi_last) begin
            // Period boundary: the only point where enable and reloads take effect.
            cnt_q <= '0;
            div_q <= 1'b0;
            if (!i_clk_en) begin
              state_q <= ST_STOP;
            end else if (pend_q || i_load) begin
              r_act_q <= load_ratio_d;
              ack_q   <= 1'b1;
              pend_q  <= 1'b0;
              if (load_ratio_d < THR) begin
                state_q <= ST_BYPASS;
                tick_q  <= 1'b1;
              end else begin
                state_q <= ST_LOW;
              end
            end else begin
              state_q <= ST_LOW;
            end
          end else begin
            cnt_q <= cnt_q + ONE;
            div_q <= 1'b1;
          end
        end
        default: state_q <= ST_STOP;
      endcase
    end
  end

`ifdef CLK_DIV_ODD50_EN
  logic odd_ratio, ext_hi;
  assign odd_ratio = r_act_q[0] && (r_act_q != ONE);

  clk_div_odd_ext u_odd_ext (
    .clk_i  (i_ref_clk),
    .rst_ni (i_rst_n),
    .hi_i   (div_q),
    .odd_i  (odd_ratio),
    .ext_o  (ext_hi)
  );

  assign div_out = div_q | ext_hi;
`else
  assign div_out = div_q;
`endif

  always_comb begin
    o_div_clk = 1'b0;
    case (sel_q)
      SEL_REF: o_div_clk = i_ref_clk;
      SEL_DIV: o_div_clk = div_out;
      default: o_div_clk = 1'b0;
    endcase
  end

  assign o_tick      = tick_q;
  assign o_ratio_ack = ack_q;

endmodule
